// File: rtl/ife_param.sv
// ife_param: 3x3 neighbourhood filter engine (min / max / median / mean) that streams
// a raster image from an image ROM into a result RAM, one output pixel every 11 cycles.
module ife_param #(
  parameter int IMG_W    = 128,
  parameter int IMG_H    = 128,
  parameter int DW       = 8,
  parameter int AW       = 14,
  parameter int PAD_MODE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  input  logic [1:0]    sel,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_wr,
  output logic          wen
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE
  } state_t;

  localparam int              SUMW     = DW + 4;
  localparam logic [AW-1:0]   W_A      = AW'(IMG_W);
  localparam logic [AW-1:0]   LAST_COL = AW'(IMG_W - 1);
  localparam logic [AW-1:0]   LAST_ROW = AW'(IMG_H - 1);
  localparam logic [SUMW-1:0] NINE     = SUMW'(9);

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [AW-1:0]   row_q, row_d;
  logic [AW-1:0]   col_q, col_d;
  logic [3:0]      tap_q, tap_d;
  logic            oob_q, oob_d;
  logic [DW-1:0]   s_q [9];
  logic [DW-1:0]   s_d [9];
  logic [SUMW-1:0] sum_q, sum_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            wen_q, wen_d;

  int              tap_row, tap_col, clamp_row, clamp_col;
  logic            tap_oob;
  logic [AW-1:0]   tap_addr;
  logic [DW-1:0]   sample;
  logic [DW-1:0]   ins [9];

  // Tap k covers (dr,dc) = (k/3-1, k%3-1); the clamped coordinate always gives a legal address.
  always_comb begin
    tap_row   = int'(row_q) + int'(tap_q / 4'd3) - 1;
    tap_col   = int'(col_q) + int'(tap_q % 4'd3) - 1;
    clamp_row = tap_row;
    clamp_col = tap_col;
    if (tap_row < 0)          clamp_row = 0;
    else if (tap_row > IMG_H - 1) clamp_row = IMG_H - 1;
    if (tap_col < 0)          clamp_col = 0;
    else if (tap_col > IMG_W - 1) clamp_col = IMG_W - 1;
    tap_oob  = (clamp_row != tap_row) || (clamp_col != tap_col);
    tap_addr = AW'(clamp_row) * W_A + AW'(clamp_col);
  end

  // Descending insertion: a new sample lands after every entry that is >= it.
  always_comb begin
    sample = (PAD_MODE == 0 && oob_q) ? '0 : idata;
    ins[0] = (s_q[0] >= sample) ? s_q[0] : sample;
    for (int i = 1; i < 9; i++) begin
      if (s_q[i] >= sample)          ins[i] = s_q[i];
      else if (s_q[i-1] >= sample)   ins[i] = sample;
      else                           ins[i] = s_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    row_d   = row_q;
    col_d   = col_q;
    tap_d   = tap_q;
    oob_d   = oob_q;
    s_d     = s_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wen_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ready) begin
          mode_d  = sel;
          row_d   = '0;
          col_d   = '0;
          tap_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        oob_d = tap_oob;
        if (tap_q == 4'd0) begin
          for (int i = 0; i < 9; i++) s_d[i] = '0;
          sum_d = '0;
        end else begin
          s_d   = ins;
          sum_d = sum_q + {4'b0000, sample};
        end
        if (tap_q == 4'd8) begin
          tap_d   = '0;
          state_d = S_DRAIN;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      S_DRAIN: begin
        s_d    = ins;
        sum_d  = sum_q + {4'b0000, sample};
        addr_d = row_q * W_A + col_q;
        wen_d  = 1'b1;
        case (mode_q)
          2'b00:   data_d = s_d[8];
          2'b01:   data_d = s_d[0];
          2'b10:   data_d = s_d[4];
          default: data_d = DW'(sum_d / NINE);
        endcase
        state_d = S_WRITE;
      end
      S_WRITE: begin
        tap_d = '0;
        if (row_q == LAST_ROW && col_q == LAST_COL) begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_IDLE;
        end else if (col_q == LAST_COL) begin
          col_d   = '0;
          row_d   = row_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      tap_q   <= '0;
      oob_q   <= 1'b0;
      for (int i = 0; i < 9; i++) s_q[i] <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tap_q   <= tap_d;
      oob_q   <= oob_d;
      s_q     <= s_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign iaddr   = (state_q == S_FETCH) ? tap_addr : '0;
  assign addr    = addr_q;
  assign data_wr = data_q;
  assign wen     = wen_q;

endmodule

// File: doc/ife_param.md
Name: ife_param

Overview:
- Parametrised 3x3 neighbourhood image filter engine for the image-processing datapath; successor to the fixed 128x128 min-filter engine.
- Reads a raster image from the image ROM through iaddr/idata and writes one filtered pixel per position to the result RAM through addr/data_wr/wen.
- Adds configurable image size and pixel width, four run-time filter modes (min, max, median, mean) and a selectable border policy (zero pad or edge replicate).

Parameters:
- IMG_W, 128, image width in pixels, at least 2.
- IMG_H, 128, image height in pixels, at least 2.
- DW, 8, pixel width in bits.
- AW, 14, address width; IMG_W*IMG_H must not exceed 2^AW.
- PAD_MODE, 0, border policy: 0 = zero padding, 1 = replicate (clamp coordinates to image).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ready  in  1  start request, sampled only in IDLE.
- busy  out  1  high from the first fetch cycle until the last write has completed.
- sel  in  2  filter mode, latched at start: 00 min, 01 max, 10 median, 11 mean.
- iaddr  out  AW  image ROM read address.
- idata  in  DW  image ROM data; valid the cycle after iaddr is presented.
- addr  out  AW  result RAM write address.
- data_wr  out  DW  result RAM write data.
- wen  out  1  result RAM write strobe, one cycle per pixel.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy, wen, iaddr, addr and data_wr all 0; row, column and tap counters 0; sort registers and accumulator 0.
- IDLE: if ready=1 at a rising edge, latch sel into mode_r, set row=col=0 and go to FETCH. When not in IDLE, ready is ignored.
- Per pixel, 11 cycles, states FETCH(k=0..8) -> DRAIN -> WRITE:
  - FETCH k presents the address of tap k, with taps in row-major order (dr,dc) from (-1,-1) to (+1,+1).
  - The sample for tap k-1 is captured in FETCH k; the sample for tap 8 is captured in DRAIN.
  - WRITE drives wen=1, addr = row*IMG_W + col, data_wr = result for exactly one cycle.
- Border handling, per tap:
  - PAD_MODE=0: an out-of-image tap uses value 0 in place of idata. iaddr for that tap is don't-care but must stay in range 0..IMG_W*IMG_H-1.
  - PAD_MODE=1: row and column are clamped to [0,IMG_H-1] and [0,IMG_W-1] before forming iaddr; idata is always used.
- Datapath per pixel, cleared at FETCH 0:
  - A 9-entry descending insertion register s[0..8] (s[0] largest) takes one sample per capture cycle. Equal values are inserted after existing equals.
  - A (DW+4)-bit sum accumulates every sample.
- Result by mode_r: min = s[8]; max = s[0]; median = s[4]; mean = floor(sum/9), exact integer divide, always fits in DW.
- After WRITE: col increments. On col=IMG_W-1, col wraps to 0 and row increments. After the write for (IMG_H-1, IMG_W-1), go to IDLE; busy falls in the following cycle.
- Total busy duration is 11*IMG_W*IMG_H cycles.
- Outside WRITE, wen=0; addr and data_wr hold their last values.
- sel changes during a frame have no effect.
- Reset mid-frame aborts immediately: wen=0 with no partial write. The next ready restarts from pixel 0.

Test Plan:
- Run with IMG_W=4, IMG_H=3, PAD_MODE=0 on a constant 0x10 image:
  - mean mode -> corner pixel 0x07 (64/9), edge pixel 0x0A (96/9), interior pixel 0x10.
  - median mode -> corner 0x00, edge 0x10.
  - min mode -> all 0x00 except interior (1,1) and (1,2), which are 0x10.
- Same image with PAD_MODE=1 in all four modes -> every output is 0x10.
- Ramp image p[i]=i (IMG_W=4, IMG_H=3, PAD_MODE=1), pixel (1,1):
  - taps are {0,1,2,4,5,6,8,9,10};
  - expect max 10, min 0, median 5, mean 5;
  - 12 writes to addr 0..11 in order.
- All 0xFF image, mean mode -> 0xFF everywhere with no overflow. DW=10 build on an all 0x3FF image -> 0x3FF.
- Timing check:
  - ready pulse -> busy rises the next cycle;
  - wen pulses exactly 11 cycles apart;
  - busy is high for 132 cycles (4x3);
  - ready and sel toggles while busy are ignored.
- Assert reset for one cycle during the FETCH of pixel 5 -> all outputs 0 immediately and no further wen. A later ready produces a full 12-pixel frame starting at addr 0.
